pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and all address ports.
REQ-002 Parameter STEP, default 4, sequential increment added to PC each advancing cycle.
REQ-003 Parameter RESET_VEC, default 0, PC value loaded by reset.
REQ-004 Parameter RAS_DEPTH, default 4, entries in the return-address stack (RAS); legal range 1..16.
REQ-005 CLK  input  1  single clock; all state changes on rising edge only.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 STALL  input  1  hold PC and RAS unchanged this cycle.
REQ-008 BRANCH_EN  input  1  taken branch/jump: redirect PC to BRANCH_TARGET.
REQ-009 BRANCH_TARGET  input  ADDR_W  redirect address for BRANCH_EN and CALL.
REQ-010 CALL  input  1  call: push PC+STEP onto RAS, redirect PC to BRANCH_TARGET.
REQ-011 RET  input  1  return: pop RAS top into PC.
REQ-012 PC  output  ADDR_W  current program counter, registered.
REQ-013 RAS_COUNT  output  5  number of valid RAS entries, 0..RAS_DEPTH.
REQ-014 RAS_OVF  output  1  sticky flag: a CALL was made with RAS full.
REQ-015 RAS_UNF  output  1  sticky flag: a RET was made with RAS empty.

Function
REQ-016 PC SHALL update only on rising CLK; new value visible immediately after the edge (one-cycle latency from inputs to PC).
REQ-017 Per-edge priority SHALL be: RESET > STALL > RET > CALL > BRANCH_EN > sequential (PC+STEP).
REQ-018 STALL=1 (no RESET): PC, RAS contents, RAS_COUNT, RAS_OVF, RAS_UNF all hold; BRANCH_EN/CALL/RET ignored and not remembered.
REQ-019 Sequential: PC <= (PC + STEP) mod 2^ADDR_W; overflow wraps silently, no flag.
REQ-020 BRANCH_EN alone: PC <= BRANCH_TARGET; RAS untouched.
REQ-021 CALL: push (PC+STEP) mod 2^ADDR_W, PC <= BRANCH_TARGET regardless of BRANCH_EN, RAS_COUNT += 1.
REQ-022 CALL with RAS_COUNT=RAS_DEPTH: oldest entry discarded (circular), new entry becomes top, RAS_COUNT stays RAS_DEPTH, RAS_OVF <= 1.
REQ-023 RET with RAS_COUNT>0: PC <= top entry, entry popped, RAS_COUNT -= 1.
REQ-024 RET with RAS_COUNT=0: PC <= PC+STEP, RAS unchanged, RAS_UNF <= 1.
REQ-025 RET and CALL in same cycle: RET executes, CALL fully ignored (no push, no OVF).
REQ-026 RET and BRANCH_EN in same cycle: RET executes, branch ignored.
REQ-027 After overflow discards, subsequent pops SHALL return the most recent RAS_DEPTH pushes in LIFO order; further pops hit underflow per REQ-024.
REQ-028 BRANCH_TARGET SHALL be used unaligned as given; no masking to STEP alignment.

Reset
REQ-029 RESET=1 at rising edge: PC <= RESET_VEC, RAS_COUNT <= 0, RAS_OVF <= 0, RAS_UNF <= 0; RAS storage contents don't-care.
REQ-030 RESET overrides STALL, CALL, RET, BRANCH_EN in the same cycle.
REQ-031 Before first reset edge, output values are undefined; bench SHALL apply RESET for at least one edge.
REQ-032 RESET mid-call-sequence discards all RAS entries; a following RET underflows.

Verification (ADDR_W=32, STEP=4, RAS_DEPTH=4, RESET_VEC=0)
REQ-033 Reset 1 cycle, then 3 free-run cycles -> PC 0x0, 0x4, 0x8, 0xC; RAS_COUNT=0, flags 0.
REQ-034 PC=0x10, CALL target 0x100, 2 free cycles, RET -> PC 0x100, 0x104, 0x108, 0x14; RAS_COUNT 1 then 0.
REQ-035 Five CALLs from PC 0x0 to targets 0x100,0x200,0x300,0x400,0x500 -> RAS_OVF=1, RAS_COUNT=4; five RETs -> PC 0x404,0x304,0x204,0x104, then 5th RET gives 0x108 and RAS_UNF=1.
REQ-036 STALL=1 for 3 cycles with BRANCH_EN=1, target 0x80, at PC=0x20 -> PC stays 0x20; after release with BRANCH_EN=0 -> PC 0x24.
REQ-037 PC=0xFFFFFFFC, free-run -> PC 0x00000000, no flag change.
REQ-038 CALL+RET same cycle with RAS holding 0x44 -> PC 0x44, RAS_COUNT 0, RAS_OVF unchanged; RESET+CALL same cycle -> PC 0x0, RAS_COUNT 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer with sequential advance, branch/call redirect and a
// circular return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              BRANCH_EN,
    input  logic [ADDR_W-1:0] BRANCH_TARGET,
    input  logic              CALL,
    input  logic              RET,
    output logic [ADDR_W-1:0] PC,
    output logic [4:0]        RAS_COUNT,
    output logic              RAS_OVF,
    output logic              RAS_UNF
);

    // Storage is rounded up to a power of two so the pointer indexes it exactly.
    localparam int PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_SLOTS = 2 ** PTR_W;

    logic [ADDR_W-1:0] ras_mem [RAS_SLOTS];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [ADDR_W-1:0] pc_seq;
    logic              ras_full;
    logic              ras_empty;
    logic              do_ret;
    logic              do_call;

    assign pc_seq    = PC + ADDR_W'(STEP);
    assign ras_full  = (RAS_COUNT == 5'(RAS_DEPTH));
    assign ras_empty = (RAS_COUNT == 5'd0);
    assign do_ret    = !RESET && !STALL && RET;
    assign do_call   = !RESET && !STALL && !RET && CALL;

    // wr_ptr names the next slot to fill; when full it also names the oldest entry,
    // so a push on a full stack overwrites the oldest entry without extra logic.
    assign ptr_inc = (wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign ptr_dec = (wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr - 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC        <= RESET_VEC;
            RAS_COUNT <= 5'd0;
            RAS_OVF   <= 1'b0;
            RAS_UNF   <= 1'b0;
            wr_ptr    <= '0;
        end else if (!STALL) begin
            if (RET) begin
                if (!ras_empty) begin
                    PC        <= ras_mem[ptr_dec];
                    wr_ptr    <= ptr_dec;
                    RAS_COUNT <= RAS_COUNT - 5'd1;
                end else begin
                    PC      <= pc_seq;
                    RAS_UNF <= 1'b1;
                end
            end else if (CALL) begin
                PC     <= BRANCH_TARGET;
                wr_ptr <= ptr_inc;
                if (ras_full) begin
                    RAS_OVF <= 1'b1;
                end else begin
                    RAS_COUNT <= RAS_COUNT + 5'd1;
                end
            end else if (BRANCH_EN) begin
                PC <= BRANCH_TARGET;
            end else begin
                PC <= pc_seq;
            end
        end
    end

    // NOTE: the stack storage is deliberately not reset; RAS_COUNT alone decides
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge CLK) begin
        if (do_call) begin
            ras_mem[wr_ptr] <= pc_seq;
        end
    end

    logic unused_ret_flag;
    assign unused_ret_flag = do_ret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with the default parameters.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_EN;
    logic [31:0] BRANCH_TARGET;
    logic        CALL;
    logic        RET;
    logic [31:0] PC;
    logic [4:0]  RAS_COUNT;
    logic        RAS_OVF;
    logic        RAS_UNF;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .ADDR_W   (32),
        .STEP     (4),
        .RESET_VEC(32'h0),
        .RAS_DEPTH(4)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .STALL        (STALL),
        .BRANCH_EN    (BRANCH_EN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .CALL         (CALL),
        .RET          (RET),
        .PC           (PC),
        .RAS_COUNT    (RAS_COUNT),
        .RAS_OVF      (RAS_OVF),
        .RAS_UNF      (RAS_UNF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RESET = 0; STALL = 0; BRANCH_EN = 0; CALL = 0; RET = 0; BRANCH_TARGET = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        RESET = 1;
        step();
        RESET = 0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input int cnt,
                             input logic ovf, input logic unf);
        check({tag, ".pc"},  PC,                pc);
        check({tag, ".cnt"}, 32'(RAS_COUNT),    32'(cnt));
        check({tag, ".ovf"}, 32'(RAS_OVF),      32'(ovf));
        check({tag, ".unf"}, 32'(RAS_UNF),      32'(unf));
    endtask

    logic [31:0] call_tgt [5] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};
    logic [31:0] ret_pc   [5] = '{32'h404, 32'h304, 32'h204, 32'h104, 32'h108};
    int          ret_cnt  [5] = '{3, 2, 1, 0, 0};

    initial begin
        idle();
        #2;
        do_reset();
        chk_state("reset", 32'h0, 0, 0, 0);

        // Free run after reset
        step(); chk_state("run1", 32'h4, 0, 0, 0);
        step(); chk_state("run2", 32'h8, 0, 0, 0);
        step(); chk_state("run3", 32'hC, 0, 0, 0);

        // Call / two free cycles / return
        step(); check("at10", PC, 32'h10);
        CALL = 1; BRANCH_TARGET = 32'h100;
        step(); chk_state("call1", 32'h100, 1, 0, 0);
        CALL = 0;
        step(); check("c104", PC, 32'h104);
        step(); check("c108", PC, 32'h108);
        RET = 1;
        step(); chk_state("ret1", 32'h14, 0, 0, 0);
        RET = 0;

        // Stall blocks a pending branch and does not remember it
        BRANCH_EN = 1; BRANCH_TARGET = 32'h20;
        step(); check("br20", PC, 32'h20);
        STALL = 1; BRANCH_TARGET = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step(); chk_state($sformatf("stall%0d", i), 32'h20, 0, 0, 0);
        end
        STALL = 0; BRANCH_EN = 0;
        step(); check("unstall", PC, 32'h24);

        // Stall also holds the stack and blocks call/ret
        STALL = 1; CALL = 1; BRANCH_TARGET = 32'h300;
        step(); chk_state("stall_call", 32'h24, 0, 0, 0);
        CALL = 0; RET = 1;
        step(); chk_state("stall_ret", 32'h24, 0, 0, 0);
        STALL = 0; RET = 0;

        // Five calls overflow a depth-4 stack, five returns unwind then underflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            CALL = 1; BRANCH_TARGET = call_tgt[i];
            step();
            chk_state($sformatf("ovf_call%0d", i), call_tgt[i], (i < 4) ? i + 1 : 4, (i == 4), 0);
        end
        CALL = 0;
        for (int i = 0; i < 5; i++) begin
            RET = 1;
            step();
            chk_state($sformatf("ovf_ret%0d", i), ret_pc[i], ret_cnt[i], 1, (i == 4));
        end
        RET = 0;

        // Address wrap, flags untouched; unaligned target used as given
        BRANCH_EN = 1; BRANCH_TARGET = 32'hFFFF_FFFC;
        step(); check("brtop", PC, 32'hFFFF_FFFC);
        BRANCH_EN = 0;
        step(); chk_state("wrap", 32'h0, 0, 1, 1);
        BRANCH_EN = 1; BRANCH_TARGET = 32'h103;
        step(); check("unal", PC, 32'h103);
        BRANCH_EN = 0;
        step(); check("unal_seq", PC, 32'h107);

        // CALL and RET together: return wins, nothing pushed
        do_reset();
        BRANCH_EN = 1; BRANCH_TARGET = 32'h40;
        step(); check("br40", PC, 32'h40);
        BRANCH_EN = 0; CALL = 1; BRANCH_TARGET = 32'h200;
        step(); chk_state("call44", 32'h200, 1, 0, 0);
        RET = 1; BRANCH_TARGET = 32'h300;
        step(); chk_state("callret", 32'h44, 0, 0, 0);
        CALL = 0;
        step(); chk_state("ret_unf", 32'h48, 0, 0, 1);
        RET = 0;

        // CALL+RET on a full stack raises no overflow; RET beats BRANCH_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            CALL = 1; BRANCH_TARGET = call_tgt[i];
            step();
        end
        check("full_cnt", 32'(RAS_COUNT), 32'd4);
        RET = 1; BRANCH_TARGET = 32'h900;
        step(); chk_state("full_callret", 32'h304, 3, 0, 0);
        CALL = 0; BRANCH_EN = 1; BRANCH_TARGET = 32'h800;
        step(); chk_state("ret_br", 32'h204, 2, 0, 0);
        RET = 0; BRANCH_EN = 0;

        // Reset beats a simultaneous call and discards the stack
        do_reset();
        CALL = 1; BRANCH_TARGET = 32'h500;
        step(); chk_state("pre_rst_call", 32'h500, 1, 0, 0);
        RESET = 1; STALL = 1; RET = 1; BRANCH_EN = 1;
        step(); chk_state("rst_call", 32'h0, 0, 0, 0);
        RESET = 0; STALL = 0; CALL = 0; BRANCH_EN = 0;
        step(); chk_state("rst_ret", 32'h4, 0, 0, 1);
        RET = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
